slave_out_writer: RTL

SLAVE_OUT_WRITER -- requirements
Module: slave_out_writer

---
 rtl/slave_out_writer.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/slave_out_writer.sv
// Streams accelerator result lines to sequential memory addresses and, once every
// line queued ahead of a notification has been acknowledged, writes the notification line.
module slave_out_writer #(
    parameter int FIFO_DEPTH = 64,
    parameter int OUTST_W    = 10
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [41:0]  cfg_out_base,
    input  logic [41:0]  cfg_notify_addr,
    input  logic         cfg_start,
    input  logic [511:0] dout,
    input  logic         dout_valid,
    input  logic         dout_done,
    input  logic [511:0] nout,
    input  logic         nout_valid,
    output logic         wr_req_valid,
    output logic [41:0]  wr_req_addr,
    output logic [511:0] wr_req_data,
    input  logic         wr_req_almost_full,
    input  logic         wr_rsp_valid,
    output logic [31:0]  lines_written,
    output logic [15:0]  phase_count,
    output logic         busy,
    output logic         stream_done,
    output logic         err_overflow
);
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [AW:0]   FULL_COUNT = (AW + 1)'(FIFO_DEPTH);
    localparam logic [AW-1:0] PTR_ONE    = AW'(1);
    localparam logic [AW:0]   CNT_ONE    = (AW + 1)'(1);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        STREAM     = 3'd1,
        DRAIN      = 3'd2,
        NOTIFY     = 3'd3,
        NOTIFY_ACK = 3'd4
    } state_t;

    state_t              state_r, state_s;
    logic [41:0]         wr_ptr_r, notify_addr_r;
    logic [511:0]        notify_data_r;
    logic [511:0]        fifo_mem_r [FIFO_DEPTH];
    logic [AW-1:0]       head_r, tail_r;
    logic [AW:0]         count_r;
    logic [OUTST_W-1:0]  outst_r;
    logic                wr_req_valid_r;
    logic [41:0]         wr_req_addr_r;
    logic [511:0]        wr_req_data_r;
    logic [31:0]         lines_written_r;
    logic [15:0]         phase_count_r;
    logic                stream_done_r, err_overflow_r;

    logic fifo_empty_s, fifo_full_s, outst_zero_s;
    logic start_s, data_issue_s, bypass_s, pop_s, push_s, drop_s;
    logic notify_issue_s, nout_capture_s, nout_overwrite_s, rsp_dec_s, issue_any_s;

    assign fifo_empty_s = (count_r == {(AW + 1){1'b0}});
    assign fifo_full_s  = (count_r == FULL_COUNT);
    assign outst_zero_s = (outst_r == {OUTST_W{1'b0}});

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic; DRAIN holds while a line is still arriving so it gets issued first
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE:       if (cfg_start) state_s = STREAM; else state_s = IDLE;
            STREAM:     if (nout_valid) state_s = DRAIN; else state_s = STREAM;
            DRAIN:      if (fifo_empty_s && outst_zero_s && !dout_valid) state_s = NOTIFY;
                        else state_s = DRAIN;
            NOTIFY:     if (!wr_req_almost_full) state_s = NOTIFY_ACK; else state_s = NOTIFY;
            NOTIFY_ACK: if (outst_zero_s) state_s = STREAM; else state_s = NOTIFY_ACK;
            default:    state_s = IDLE;
        endcase
    end

    // Per-state control decode; an empty FIFO lets an arriving line bypass straight to the request
    always_comb begin
        start_s          = 1'b0;
        data_issue_s     = 1'b0;
        notify_issue_s   = 1'b0;
        nout_capture_s   = 1'b0;
        nout_overwrite_s = 1'b0;
        case (state_r)
            IDLE: start_s = cfg_start;
            STREAM: begin
                data_issue_s   = !wr_req_almost_full && (!fifo_empty_s || dout_valid);
                nout_capture_s = nout_valid;
            end
            DRAIN: begin
                data_issue_s     = !wr_req_almost_full && (!fifo_empty_s || dout_valid);
                nout_overwrite_s = nout_valid;
            end
            NOTIFY: begin
                notify_issue_s   = !wr_req_almost_full;
                nout_overwrite_s = nout_valid;
            end
            NOTIFY_ACK: nout_overwrite_s = nout_valid;
            default:    start_s = 1'b0;
        endcase
        bypass_s    = data_issue_s && fifo_empty_s;
        pop_s       = data_issue_s && !fifo_empty_s;
        push_s      = (state_r != IDLE) && dout_valid && !bypass_s && !fifo_full_s;
        drop_s      = (state_r != IDLE) && dout_valid && !bypass_s && fifo_full_s;
        rsp_dec_s   = wr_rsp_valid && !outst_zero_s;
        issue_any_s = data_issue_s || notify_issue_s;
    end

    // FIFO storage
    always_ff @(posedge clk) begin
        if (push_s) begin
            fifo_mem_r[tail_r] <= dout;
        end
    end

    // FIFO pointers and occupancy, flushed on each new run
    always_ff @(posedge clk) begin
        if (reset || start_s) begin
            head_r  <= {AW{1'b0}};
            tail_r  <= {AW{1'b0}};
            count_r <= {(AW + 1){1'b0}};
        end else begin
            if (push_s) tail_r <= tail_r + PTR_ONE;
            if (pop_s)  head_r <= head_r + PTR_ONE;
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    // Outstanding write counter; a stray ack at zero is ignored
    always_ff @(posedge clk) begin
        if (reset) begin
            outst_r <= {OUTST_W{1'b0}};
        end else begin
            case ({issue_any_s, rsp_dec_s})
                2'b10:   outst_r <= outst_r + {{(OUTST_W - 1){1'b0}}, 1'b1};
                2'b01:   outst_r <= outst_r - {{(OUTST_W - 1){1'b0}}, 1'b1};
                default: outst_r <= outst_r;
            endcase
        end
    end

    // Run context: address pointer, held notification, counters and sticky flags
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_r        <= 42'd0;
            notify_addr_r   <= 42'd0;
            notify_data_r   <= 512'd0;
            lines_written_r <= 32'd0;
            phase_count_r   <= 16'd0;
            stream_done_r   <= 1'b0;
            err_overflow_r  <= 1'b0;
        end else begin
            if (start_s) begin
                wr_ptr_r        <= cfg_out_base;
                notify_addr_r   <= cfg_notify_addr;
                lines_written_r <= 32'd0;
                phase_count_r   <= 16'd0;
                stream_done_r   <= 1'b0;
                err_overflow_r  <= 1'b0;
            end else begin
                if (data_issue_s) begin
                    wr_ptr_r        <= wr_ptr_r + 42'd1;
                    lines_written_r <= lines_written_r + 32'd1;
                end
                if ((state_r == NOTIFY_ACK) && outst_zero_s) phase_count_r <= phase_count_r + 16'd1;
                if (dout_done) stream_done_r <= 1'b1;
                if (drop_s || nout_overwrite_s) err_overflow_r <= 1'b1;
            end
            if (nout_capture_s || nout_overwrite_s) notify_data_r <= nout;
        end
    end

    // Registered write request
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_req_valid_r <= 1'b0;
            wr_req_addr_r  <= 42'd0;
            wr_req_data_r  <= 512'd0;
        end else if (data_issue_s) begin
            wr_req_valid_r <= 1'b1;
            wr_req_addr_r  <= wr_ptr_r;
            wr_req_data_r  <= bypass_s ? dout : fifo_mem_r[head_r];
        end else if (notify_issue_s) begin
            wr_req_valid_r <= 1'b1;
            wr_req_addr_r  <= notify_addr_r;
            wr_req_data_r  <= notify_data_r;
        end else begin
            wr_req_valid_r <= 1'b0;
        end
    end

    assign wr_req_valid  = wr_req_valid_r;
    assign wr_req_addr   = wr_req_addr_r;
    assign wr_req_data   = wr_req_data_r;
    assign lines_written = lines_written_r;
    assign phase_count   = phase_count_r;
    assign busy          = (state_r != IDLE);
    assign stream_done   = stream_done_r;
    assign err_overflow  = err_overflow_r;
endmodule
